uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares a single UART transmitter core (start/data in, busy out) between NREQ byte-stream requesters.
- Requesters offer bytes with a valid/ready handshake and mark packet ends with a last flag.
- Round-robin arbitration happens only at packet boundaries. The grant is locked until the last byte of the packet has fully shifted out.
- Sits between on-board byte sources and the UART transmitter that drives UART_RXD_OUT.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1023, cycles allowed for tx_busy to rise after tx_start, and max idle cycles inside a locked packet.
- TW, 10, width of timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz, all logic on rising edge.
- SW0  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  byte of requester i at bits [8i+7:8i].
- req_last  in  NREQ  byte is final byte of its packet.
- req_ready  out  NREQ  one-hot, 1-cycle accept pulse.
- grant  out  NREQ  one-hot current owner; 0 when unowned.
- tx_start  out  1  1-cycle start pulse to transmitter.
- tx_data  out  8  byte to transmitter; registered.
- tx_busy  in  1  transmitter busy (high while frame shifting).
- arb_busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky error flag; cleared only by SW0.

Behaviour:
- Reset (SW0=1 at clock edge): state=IDLE; grant=0, req_ready=0, tx_start=0, tx_data=8'h00, timeout_err=0, rr pointer=0, counter=0. Reset mid-frame aborts immediately; the transmitter is not told.
- Handshake rule: once a requester raises req_valid, it must hold req_valid/req_data/req_last stable until it sees req_ready.
- States: IDLE, SEND, WAIT_ACK, WAIT_DONE, HOLD.
- IDLE:
  - If any req_valid: winner = first set bit searching from index ptr upward, wrapping mod NREQ.
  - Register grant=onehot(winner); go SEND.
  - With no request, stay in IDLE.
- SEND (exactly 1 cycle):
  - tx_start=1; req_ready[owner]=1.
  - tx_data <= req_data[owner]; capture last_q <= req_last[owner].
  - Clear counter; go WAIT_ACK.
  - Latency: req_valid sampled in IDLE at cycle N → tx_start and req_ready in cycle N+1.
- WAIT_ACK:
  - tx_busy=1 → WAIT_DONE.
  - Otherwise increment counter. At counter==TIMEOUT: set timeout_err, grant=0, ptr=owner+1, go IDLE (byte dropped).
- WAIT_DONE: wait for tx_busy=0, then:
  - last_q=1: grant=0, ptr=owner+1 (mod NREQ), go IDLE.
  - last_q=0 and req_valid[owner]=1: go SEND (back-to-back; one idle cycle between busy fall and next start).
  - last_q=0 and req_valid[owner]=0: go HOLD, clear counter.
- HOLD:
  - Grant stays locked; other requesters are ignored.
  - req_valid[owner]=1 → SEND.
  - Counter reaching TIMEOUT → timeout_err=1, release as in the last-byte case.
- tx_data remains stable from the cycle after SEND until the next SEND.
- req_ready is never asserted for a non-owner. At most one req_ready bit is high, and only in SEND.
- Simultaneous requests in IDLE: pointer order decides; after reset requester 0 has top priority.
- A requester dropping req_valid before ready is a protocol violation. It is not checked; the stale byte may still be sent.
- Pointer arithmetic: ptr is $clog2(NREQ) bits; (owner+1)==NREQ wraps to 0.
- arb_busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg:
  - state enum/localparams (IDLE=0, SEND=1, WAIT_ACK=2, WAIT_DONE=3, HOLD=4);
  - BYTE_W=8;
  - onehot/index conversion function.
- One sub-module, uart_rr_pick (combinational): inputs req vector and ptr; outputs winner index and any_req. Instanced once.
- Timeout counter and FSM stay in the top.

Test Plan:
- Reset, then req_valid=4'b0001, data 8'h41, last=1, with a model transmitter asserting busy 2 cycles after start for 100 cycles. Required: grant=0001 one cycle after valid; one tx_start; tx_data=8'h41; req_ready pulsed once; back to IDLE after busy falls; ptr=1.
- Requesters 0 and 2 both valid, each with a single-byte packet (8'h10, 8'h30). Required: order 0 then 2. Then with ptr=3 and both valid again: 0 wins before 2 (wrap).
- Requester 1 sends a 3-byte packet 8'hA1,A2,A3 (last on A3) while requester 3 is valid throughout. Required: all three A-bytes sent before any 3-byte; grant stays 0010 across all three.
- Mid-packet, requester 1 drops valid for 50 cycles (< TIMEOUT). Required: HOLD entered, requester 3 still blocked, resume on revalid. Then a gap of TIMEOUT+5 cycles: timeout_err=1, grant released, requester 3 served next.
- Transmitter model never asserts busy. Required: after TIMEOUT cycles in WAIT_ACK, timeout_err=1, grant=0, IDLE. A later SW0 pulse clears timeout_err.
- SW0 asserted for 1 cycle during WAIT_DONE. Required: next cycle all outputs at reset values, ptr=0, requester 0 wins the next arbitration.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - state_t      : arbiter FSM states
//   - BYTE_W       : width of one transmitted byte
//   - MAX_REQ      : largest supported requester count
//   - idx_to_onehot / onehot_to_idx : conversions between a requester index
//                    and its one-hot grant vector (sized for MAX_REQ)
package uart_pkg;

  localparam int BYTE_W  = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_t;

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Grant vectors are one-hot by construction; an all-zero vector maps to 0.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte stream bundle of the UART transmit arbiter.
//   req_valid [NREQ]        : byte offered by requester i
//   req_data  [8*NREQ]      : byte of requester i at bits [8i+7:8i]
//   req_last  [NREQ]        : offered byte ends its packet
//   req_ready [NREQ]        : one-hot, single-cycle accept pulse
// master = byte sources, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  import uart_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [BYTE_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index with highest priority this round
//   winner  : first set bit of req searching upward from ptr, wrapping
//   any_req : at least one request present (winner is only meaningful then)
module uart_rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            any_req
);

  // Walk from the farthest candidate back to ptr so the closest hit wins.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = ptr;
    any_req = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx[PW-1:0]]) winner = idx[PW-1:0];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte-stream requesters.
// Arbitration is round-robin at packet boundaries only; a grant stays locked
// until the packet's last byte has fully shifted out, or a timeout fires.
//   CLK100MHZ   : system clock
//   SW0         : synchronous active-high reset
//   rq          : requester byte streams (slave side)
//   grant       : one-hot current owner, 0 when unowned
//   tx_start    : single-cycle start pulse to the transmitter
//   tx_data     : registered byte to the transmitter
//   tx_busy     : transmitter is shifting a frame
//   arb_busy    : arbiter is not idle
//   timeout_err : sticky, cleared only by SW0
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic              CLK100MHZ,
  input  logic              SW0,
  uart_tx_arbiter_if.slave  rq,
  output logic [NREQ-1:0]   grant,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              arb_busy,
  output logic              timeout_err
);

  localparam int            PW          = $clog2(NREQ);
  localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   grant_reg, grant_next;
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic [TW-1:0]     cnt_reg, cnt_next;
  logic [BYTE_W-1:0] tx_data_reg, tx_data_next;
  logic              last_reg, last_next;
  logic              err_reg, err_next;

  logic [BYTE_W-1:0] req_byte [NREQ];
  logic [PW-1:0]     winner;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     owner_inc;
  logic              any_req;
  logic              owner_valid;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign req_byte[gi]     = rq.req_data[BYTE_W*gi +: BYTE_W];
    // Only the owner can see ready, and only during its SEND cycle.
    assign rq.req_ready[gi] = (state_reg == SEND) && grant_reg[gi];
  end

  uart_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req     (rq.req_valid),
    .ptr     (ptr_reg),
    .winner  (winner),
    .any_req (any_req)
  );

  assign owner       = PW'(onehot_to_idx(MAX_REQ'(grant_reg)));
  assign owner_inc   = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
  assign owner_valid = rq.req_valid[owner];

  always_ff @(posedge CLK100MHZ) begin
    if (SW0) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      tx_data_reg <= '0;
      last_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      tx_data_reg <= tx_data_next;
      last_reg    <= last_next;
      err_reg     <= err_next;
    end
  end

  // The byte and its last flag are latched on every transition into SEND, so
  // tx_data is already valid while tx_start is high and holds until the next
  // SEND. The requester keeps its byte stable until ready, so the value
  // sampled on entry is the one being accepted.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    tx_data_next = tx_data_reg;
    last_next    = last_reg;
    err_next     = err_reg;

    unique case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next   = NREQ'(idx_to_onehot(3'(winner)));
          tx_data_next = req_byte[winner];
          last_next    = rq.req_last[winner];
          state_next   = SEND;
        end
      end

      SEND: begin
        cnt_next   = '0;
        state_next = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          // Transmitter never acknowledged: drop the byte and release.
          err_next   = 1'b1;
          grant_next = '0;
          ptr_next   = owner_inc;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + TW'(1);
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_reg) begin
            grant_next = '0;
            ptr_next   = owner_inc;
            state_next = IDLE;
          end else if (owner_valid) begin
            tx_data_next = req_byte[owner];
            last_next    = rq.req_last[owner];
            state_next   = SEND;
          end else begin
            cnt_next   = '0;
            state_next = HOLD;
          end
        end
      end

      HOLD: begin
        // Grant stays locked mid-packet; other requesters are ignored here.
        if (owner_valid) begin
          tx_data_next = req_byte[owner];
          last_next    = rq.req_last[owner];
          state_next   = SEND;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          err_next   = 1'b1;
          grant_next = '0;
          ptr_next   = owner_inc;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + TW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign grant       = grant_reg;
  assign tx_start    = (state_reg == SEND);
  assign tx_data     = tx_data_reg;
  assign arb_busy    = (state_reg != IDLE);
  assign timeout_err = err_reg;

endmodule
